// File: rtl/adc128s102_pkg.sv
// Shared constants and types for the ADC128S102 responder model.
// Frame layout: 4 leading zeros followed by a 12-bit sample, MSB first.
// Address bits ADD2..ADD0 are sampled on sclk rises 3, 4 and 5 (1-based).
package adc128s102_pkg;

   localparam int unsigned FRAME_BITS      = 16;
   localparam int unsigned DATA_BITS       = 12;
   localparam int unsigned ADDR_BITS       = 3;
   localparam int unsigned ADDR_FIRST_RISE = 3;
   localparam int unsigned NUM_CH          = 1 << ADDR_BITS;
   localparam int unsigned CNT_W           = $clog2(FRAME_BITS + 1);

   typedef logic [CNT_W-1:0]      cnt_t;
   typedef logic [ADDR_BITS-1:0]  ch_t;
   typedef logic [DATA_BITS-1:0]  sample_t;
   typedef logic [FRAME_BITS-1:0] frame_t;

   localparam cnt_t FRAME_CNT      = cnt_t'(FRAME_BITS);
   localparam cnt_t ADDR_FIRST_CNT = cnt_t'(ADDR_FIRST_RISE);
   localparam cnt_t ADDR_LAST_CNT  = cnt_t'(ADDR_FIRST_RISE + ADDR_BITS - 1);

   typedef enum logic {
      StIdle,
      StShift
   } state_e;

   // Build the outgoing 16-bit word: zero-padded sample.
   function automatic frame_t make_frame(input sample_t s);
      return {{(FRAME_BITS - DATA_BITS){1'b0}}, s};
   endfunction

endpackage

// File: rtl/adc128s102_slave_model_if.sv
// Serial link between an ADC128S102 driver (master) and the device (slave).
//   cs_n    : chip select, active low (master -> slave)
//   sclk    : serial clock (master -> slave)
//   din     : serial control word (master -> slave)
//   dout    : serial data drive value (slave -> master)
//   dout_oe : 1 = dout driven, 0 = pin tri-stated (slave -> master)
interface adc128s102_slave_model_if;

   logic cs_n;
   logic sclk;
   logic din;
   logic dout;
   logic dout_oe;

   modport master (
      output cs_n, sclk, din,
      input  dout, dout_oe
   );

   modport slave (
      input  cs_n, sclk, din,
      output dout, dout_oe
   );

endinterface

// File: rtl/adc128s102_slave_model_in_sync.sv
// adc_in_sync: SYNC_STAGES-deep synchronizer followed by one edge-detect flop.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous pin input
//   level      : synchronized level
//   rise, fall : single-cycle edge strobes (aligned with level)
module adc_in_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc128s102_slave_model.sv
// ADC128S102 responder model. Oversamples the serial link on clk, decodes the
// channel address from the control word and shifts out 16-bit frames whose
// sample comes from eight writable channel registers. The address received in
// frame N selects the data of frame N+1.
//   clk, rst_n           : system clock, async active-low reset
//   spi                  : serial link (slave modport)
//   ch_wr/_addr/_data    : channel register write port
//   frame_done           : one-cycle pulse, 16-bit frame completed
//   frame_addr, frame_ch : address decoded / channel sent in last completed frame
//   frame_err            : one-cycle pulse, cs_n released mid-frame
module adc128s102_slave_model
   import adc128s102_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned RESET_CH    = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   adc128s102_slave_model_if.slave   spi,
   input  logic                      ch_wr,
   input  logic [ADDR_BITS-1:0]      ch_wr_addr,
   input  logic [DATA_BITS-1:0]      ch_wr_data,
   output logic                      frame_done,
   output logic [ADDR_BITS-1:0]      frame_addr,
   output logic [ADDR_BITS-1:0]      frame_ch,
   output logic                      frame_err
);

   localparam ch_t RESET_CH_V = ch_t'(RESET_CH);

   logic cs_level, cs_rise, cs_fall;
   logic sclk_level, sclk_rise, sclk_fall;
   logic din_level, din_rise, din_fall;

   // Link idles with cs_n high; reset the synchronizer there so release of
   // reset cannot fake a chip-select edge.
   adc_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst_n(rst_n), .d(spi.cs_n),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );
   adc_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst_n(rst_n), .d(spi.sclk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );
   adc_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din_sync (
      .clk(clk), .rst_n(rst_n), .d(spi.din),
      .level(din_level), .rise(din_rise), .fall(din_fall)
   );

   logic unused_edges;
   assign unused_edges = ^{cs_level, sclk_level, din_rise, din_fall};

   state_e  state_q, state_d;
   frame_t  shreg_q, shreg_d;
   cnt_t    bit_cnt_q, bit_cnt_d, cnt_inc;
   logic    dout_q, dout_d, dout_oe_q, dout_oe_d;
   ch_t     sent_ch_q, sent_ch_d, cur_ch_q, cur_ch_d, addr_nxt_q, addr_nxt_d;
   ch_t     frame_addr_q, frame_addr_d, frame_ch_q, frame_ch_d;
   logic    frame_done_q, frame_done_d, frame_err_q, frame_err_d;
   sample_t chan_reg_q [NUM_CH];

   assign cnt_inc = bit_cnt_q + cnt_t'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) chan_reg_q[i] <= '0;
      end else if (ch_wr) begin
         chan_reg_q[ch_wr_addr] <= ch_wr_data;
      end
   end

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      dout_d       = dout_q;
      dout_oe_d    = dout_oe_q;
      sent_ch_d    = sent_ch_q;
      cur_ch_d     = cur_ch_q;
      addr_nxt_d   = addr_nxt_q;
      frame_addr_d = frame_addr_q;
      frame_ch_d   = frame_ch_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               state_d   = StShift;
               shreg_d   = make_frame(chan_reg_q[cur_ch_q]);
               bit_cnt_d = '0;
               dout_oe_d = 1'b1;
               dout_d    = 1'b0;
               sent_ch_d = cur_ch_q;
            end
         end
         StShift: begin
            // cs_n release takes priority over any sclk edge in the same cycle.
            if (cs_rise) begin
               state_d   = StIdle;
               dout_oe_d = 1'b0;
               dout_d    = 1'b0;
               if (bit_cnt_q != '0 && bit_cnt_q != FRAME_CNT) frame_err_d = 1'b1;
            end else if (sclk_rise && bit_cnt_q < FRAME_CNT) begin
               bit_cnt_d = cnt_inc;
               if (cnt_inc >= ADDR_FIRST_CNT && cnt_inc <= ADDR_LAST_CNT) begin
                  addr_nxt_d = {addr_nxt_q[ADDR_BITS-2:0], din_level};
               end
               if (cnt_inc == FRAME_CNT) begin
                  frame_done_d = 1'b1;
                  frame_addr_d = addr_nxt_q;
                  frame_ch_d   = sent_ch_q;
                  cur_ch_d     = addr_nxt_q;
               end
            end else if (sclk_fall) begin
               if (bit_cnt_q < FRAME_CNT) begin
                  shreg_d = shreg_q << 1;
                  dout_d  = shreg_q[FRAME_BITS-2];
               end else begin
                  // Continuous mode: next frame starts without a cs_n toggle.
                  shreg_d   = make_frame(chan_reg_q[cur_ch_q]);
                  bit_cnt_d = '0;
                  dout_d    = 1'b0;
                  sent_ch_d = cur_ch_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         dout_q       <= 1'b0;
         dout_oe_q    <= 1'b0;
         sent_ch_q    <= RESET_CH_V;
         cur_ch_q     <= RESET_CH_V;
         addr_nxt_q   <= '0;
         frame_addr_q <= '0;
         frame_ch_q   <= RESET_CH_V;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         dout_q       <= dout_d;
         dout_oe_q    <= dout_oe_d;
         sent_ch_q    <= sent_ch_d;
         cur_ch_q     <= cur_ch_d;
         addr_nxt_q   <= addr_nxt_d;
         frame_addr_q <= frame_addr_d;
         frame_ch_q   <= frame_ch_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign spi.dout    = dout_q;
   assign spi.dout_oe = dout_oe_q;
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;
   assign frame_addr  = frame_addr_q;
   assign frame_ch    = frame_ch_q;

endmodule

// File: tb/tb_adc128s102_slave_model.sv
// Bench for adc128s102_slave_model: reset checks, a vector table of single
// frames, hand-written multi-frame sequences and randomized frames checked
// against a channel-register / pipelined-address reference model.
module tb_adc128s102_slave_model;

   localparam int HALF = 6;  // sclk half period in clk cycles

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ch_wr;
   logic [2:0]  ch_wr_addr;
   logic [11:0] ch_wr_data;
   logic        frame_done, frame_err;
   logic [2:0]  frame_addr, frame_ch;

   always #5 clk = ~clk;

   adc128s102_slave_model_if bus ();

   adc128s102_slave_model dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi        (bus),
      .ch_wr      (ch_wr),
      .ch_wr_addr (ch_wr_addr),
      .ch_wr_data (ch_wr_data),
      .frame_done (frame_done),
      .frame_addr (frame_addr),
      .frame_ch   (frame_ch),
      .frame_err  (frame_err)
   );

   int total = 0;
   int bad   = 0;
   int done_seen = 0;
   int err_seen  = 0;

   // Pulse counters: a pulse stuck high for several cycles counts several times.
   always @(negedge clk) begin
      if (frame_done === 1'b1) done_seen++;
      if (frame_err === 1'b1) err_seen++;
   end

   // Reference model: register file, channel selected for next frame, last
   // completed frame's address and channel.
   logic [11:0] model_reg [8];
   logic [2:0]  model_cur, model_faddr, model_fch;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] exp_word;
      logic [2:0]  exp_ch;
   } vec_t;
   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [11:0] v);
      ch_wr = 1'b1; ch_wr_addr = a; ch_wr_data = v;
      tick(1);
      ch_wr = 1'b0;
      model_reg[a] = v;
   endtask

   // Clock nbits bits with cs_n already low; dout sampled just before each rise.
   task automatic shift_bits(input logic [2:0] addr, input int nbits, input int wr_at,
                             input logic [2:0] wa, input logic [11:0] wv,
                             output logic [15:0] word, output int oe_bad);
      word = '0;
      oe_bad = 0;
      for (int i = 0; i < nbits; i++) begin
         case (i)
            2:       bus.din = addr[2];
            3:       bus.din = addr[1];
            4:       bus.din = addr[0];
            default: bus.din = 1'($urandom);
         endcase
         word = {word[14:0], bus.dout};
         if (bus.dout_oe !== 1'b1) oe_bad++;
         bus.sclk = 1'b1;
         tick(HALF);
         bus.sclk = 1'b0;
         if (i == wr_at) wr(wa, wv);
         tick(HALF);
      end
   endtask

   task automatic run_frame(input logic [2:0] addr, input int nbits, input int wr_at,
                            input logic [2:0] wa, input logic [11:0] wv,
                            output logic [15:0] word, output int nd, output int ne,
                            output int oe_bad);
      int d0, e0;
      d0 = done_seen; e0 = err_seen;
      bus.cs_n = 1'b0;
      tick(HALF);
      shift_bits(addr, nbits, wr_at, wa, wv, word, oe_bad);
      bus.cs_n = 1'b1;
      tick(HALF);
      nd = done_seen - d0;
      ne = err_seen - e0;
   endtask

   // Full frame checked against the reference model.
   task automatic model_frame(input string name, input logic [2:0] addr, input int wr_at,
                              input logic [2:0] wa, input logic [11:0] wv);
      logic [15:0] exp_word, word;
      logic [2:0]  exp_ch;
      int nd, ne, oeb;
      exp_word = {4'h0, model_reg[model_cur]};
      exp_ch   = model_cur;
      run_frame(addr, 16, wr_at, wa, wv, word, nd, ne, oeb);
      check({name, ".word"}, word, exp_word);
      check({name, ".done"}, nd, 1);
      check({name, ".err"}, ne, 0);
      check({name, ".faddr"}, frame_addr, addr);
      check({name, ".fch"}, frame_ch, exp_ch);
      check({name, ".oe"}, oeb, 0);
      model_cur = addr; model_faddr = addr; model_fch = exp_ch;
   endtask

   initial begin
      logic [15:0] word, w2;
      int nd, ne, oeb, oeb2, d0, e0, bad_oe, bad_dout;

      rst_n = 1'b0; ch_wr = 1'b0; ch_wr_addr = '0; ch_wr_data = '0;
      bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.din = 1'b0;
      for (int i = 0; i < 8; i++) model_reg[i] = '0;
      model_cur = 3'd0; model_faddr = 3'd0; model_fch = 3'd0;

      // Reset held while pins toggle.
      bad_oe = 0; bad_dout = 0;
      for (int i = 0; i < 20; i++) begin
         bus.cs_n = 1'($urandom); bus.sclk = 1'($urandom); bus.din = 1'($urandom);
         tick(1);
         if (bus.dout_oe !== 1'b0) bad_oe++;
         if (bus.dout !== 1'b0) bad_dout++;
      end
      check("rst.dout_oe", bad_oe, 0);
      check("rst.dout", bad_dout, 0);
      check("rst.frame_ch", frame_ch, 3'd0);
      check("rst.frame_addr", frame_addr, 3'd0);
      check("rst.pulses", done_seen + err_seen, 0);
      bus.cs_n = 1'b1; bus.sclk = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(4);

      wr(3'd0, 12'hABC); wr(3'd3, 12'h555); wr(3'd5, 12'hF0F); wr(3'd1, 12'h123);

      vecs[0] = '{addr: 3'd3, exp_word: 16'h0ABC, exp_ch: 3'd0};
      vecs[1] = '{addr: 3'd0, exp_word: 16'h0555, exp_ch: 3'd3};
      vecs[2] = '{addr: 3'd5, exp_word: 16'h0ABC, exp_ch: 3'd0};
      vecs[3] = '{addr: 3'd7, exp_word: 16'h0F0F, exp_ch: 3'd5};
      vecs[4] = '{addr: 3'd0, exp_word: 16'h0000, exp_ch: 3'd7};
      for (int v = 0; v < 5; v++) begin
         run_frame(vecs[v].addr, 16, -1, 3'd0, 12'h0, word, nd, ne, oeb);
         check($sformatf("vec%0d.word", v), word, vecs[v].exp_word);
         check($sformatf("vec%0d.done", v), nd, 1);
         check($sformatf("vec%0d.err", v), ne, 0);
         check($sformatf("vec%0d.faddr", v), frame_addr, vecs[v].addr);
         check($sformatf("vec%0d.fch", v), frame_ch, vecs[v].exp_ch);
         check($sformatf("vec%0d.oe", v), oeb, 0);
         check($sformatf("vec%0d.oe_off", v), bus.dout_oe, 1'b0);
         model_cur = vecs[v].addr; model_faddr = vecs[v].addr; model_fch = vecs[v].exp_ch;
      end

      // Continuous mode: 32 sclk under one cs_n low, ADD=5 then ADD=1.
      d0 = done_seen; e0 = err_seen;
      bus.cs_n = 1'b0;
      tick(HALF);
      shift_bits(3'd5, 16, -1, 3'd0, 12'h0, word, oeb);
      shift_bits(3'd1, 16, -1, 3'd0, 12'h0, w2, oeb2);
      bus.cs_n = 1'b1;
      tick(HALF);
      check("cont.word1", word, 16'h0ABC);
      check("cont.word2", w2, 16'h0F0F);
      check("cont.done", done_seen - d0, 2);
      check("cont.err", err_seen - e0, 0);
      check("cont.faddr", frame_addr, 3'd1);
      check("cont.fch", frame_ch, 3'd5);
      check("cont.oe", oeb + oeb2, 0);
      model_cur = 3'd1; model_faddr = 3'd1; model_fch = 3'd5;

      // Aborted frame after 8 sclk with ADD=6: error, state untouched.
      run_frame(3'd6, 8, -1, 3'd0, 12'h0, word, nd, ne, oeb);
      check("abort.word_hi", word[7:0], 8'h01);
      check("abort.err", ne, 1);
      check("abort.done", nd, 0);
      check("abort.faddr", frame_addr, 3'd1);
      check("abort.fch", frame_ch, 3'd5);
      check("abort.oe_off", bus.dout_oe, 1'b0);
      model_frame("after_abort", 3'd2, -1, 3'd0, 12'h0);   // expects 0x0123 from ch1

      // Write to the channel being sent, at sclk fall 6.
      run_frame(3'd2, 16, 5, 3'd2, 12'h9A5, word, nd, ne, oeb);
      check("midwr.word_old", word, 16'h0000);
      check("midwr.fch", frame_ch, 3'd2);
      model_cur = 3'd2; model_faddr = 3'd2; model_fch = 3'd2;
      run_frame(3'd0, 16, -1, 3'd0, 12'h0, word, nd, ne, oeb);
      check("midwr.word_new", word, 16'h09A5);
      check("midwr.next_fch", frame_ch, 3'd2);
      model_cur = 3'd0; model_faddr = 3'd0; model_fch = 3'd2;

      // Randomized frames, writes and aborts against the model.
      for (int r = 0; r < 24; r++) begin
         logic [2:0] a, wa;
         logic [11:0] wv;
         int wr_at, nb;
         if ($urandom_range(0, 2) == 0) wr(3'($urandom), 12'($urandom));
         a = 3'($urandom); wa = 3'($urandom); wv = 12'($urandom);
         wr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
         if ($urandom_range(0, 4) == 0) begin
            nb = int'($urandom_range(1, 15));
            run_frame(a, nb, -1, 3'd0, 12'h0, word, nd, ne, oeb);
            check($sformatf("rnd%0d.abort_err", r), ne, 1);
            check($sformatf("rnd%0d.abort_done", r), nd, 0);
            check($sformatf("rnd%0d.abort_faddr", r), frame_addr, model_faddr);
            check($sformatf("rnd%0d.abort_fch", r), frame_ch, model_fch);
         end else begin
            model_frame($sformatf("rnd%0d", r), a, wr_at, wa, wv);
         end
      end

      // Reset asserted mid-frame.
      d0 = done_seen; e0 = err_seen;
      bus.cs_n = 1'b0;
      tick(HALF);
      shift_bits(3'd4, 5, -1, 3'd0, 12'h0, word, oeb);
      rst_n = 1'b0;
      #1;
      check("midrst.dout_oe", bus.dout_oe, 1'b0);
      check("midrst.dout", bus.dout, 1'b0);
      tick(2);
      check("midrst.fch", frame_ch, 3'd0);
      check("midrst.faddr", frame_addr, 3'd0);
      bus.cs_n = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      check("midrst.pulses", (done_seen - d0) + (err_seen - e0), 0);
      for (int i = 0; i < 8; i++) model_reg[i] = '0;
      model_cur = 3'd0; model_faddr = 3'd0; model_fch = 3'd0;
      model_frame("postrst1", 3'd6, -1, 3'd0, 12'h0);
      wr(3'd6, 12'h7E1);
      model_frame("postrst2", 3'd0, -1, 3'd0, 12'h0);
      check("postrst2.word_const", frame_ch, 3'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
